// File: rtl/pe_array_ctrl.sv
// Command sequencer for pe_array: accepts one {instr, alg, len} command, streams len beats into
// the array and tracks each beat through the instruction-dependent latency to flag results.
module pe_array_ctrl #(
  parameter int LEN_W   = 8,
  parameter int LAT_MUL = 4,
  parameter int LAT_ADD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_instr,
  input  logic [4:0]       cmd_alg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [4:0]       pe_instr,
  output logic [4:0]       pe_alg,
  output logic             pe_fire,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  localparam int LAT_W = $clog2(LAT_MUL + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [4:0]         instr_q, instr_d;
  logic [4:0]         alg_q, alg_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issue_cnt_q, issue_cnt_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [LAT_MUL-1:0] vpipe_q, vpipe_d;
  logic [LAT_MUL-1:0] lpipe_q, lpipe_d;
  logic               err_q, err_d;
  logic               fire, last_fire, accept;

  always_comb begin
    cmd_ready   = (state_q == IDLE);
    src_ready   = (state_q == ISSUE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    fire        = src_valid & src_ready;
    last_fire   = fire && (issue_cnt_q == len_q - LEN_W'(1));
    accept      = cmd_valid & cmd_ready;

    state_d     = state_q;
    instr_d     = instr_q;
    alg_d       = alg_q;
    len_d       = len_q;
    lat_d       = lat_q;
    issue_cnt_d = issue_cnt_q;
    err_d       = 1'b0;

    if (fire) issue_cnt_d = issue_cnt_q + LEN_W'(1);

    // Stages at or beyond the active latency are forced to zero so they never leak into a later command.
    vpipe_d    = '0;
    lpipe_d    = '0;
    vpipe_d[0] = fire;
    lpipe_d[0] = last_fire;
    for (int k = 1; k < LAT_MUL; k++) begin
      if (k < int'(lat_q)) begin
        vpipe_d[k] = vpipe_q[k-1];
        lpipe_d[k] = lpipe_q[k-1];
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_alg > 5'd5) begin
            err_d = 1'b1;
          end else begin
            instr_d     = cmd_instr;
            alg_d       = cmd_alg;
            len_d       = cmd_len;
            issue_cnt_d = '0;
            lat_d       = (cmd_instr >= 5'd2 && cmd_instr <= 5'd8) ? LAT_W'(LAT_MUL) : LAT_W'(LAT_ADD);
            state_d     = (cmd_len != '0) ? ISSUE : DONE;
          end
        end
      end
      ISSUE: if (last_fire) state_d = DRAIN;
      // Leaving as the final beat retires lets done land in the very next cycle.
      DRAIN: if (vpipe_d == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    for (int k = 0; k < LAT_MUL; k++) begin
      if (k == int'(lat_q) - 1) begin
        out_valid = vpipe_q[k];
        out_last  = lpipe_q[k];
      end
    end
  end

  assign pe_fire  = fire;
  assign pe_instr = instr_q;
  assign pe_alg   = alg_q;
  assign cmd_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      alg_q       <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      lat_q       <= LAT_W'(LAT_ADD);
      vpipe_q     <= '0;
      lpipe_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      alg_q       <= alg_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      lat_q       <= lat_d;
      vpipe_q     <= vpipe_d;
      lpipe_q     <= lpipe_d;
      err_q       <= err_d;
    end
  end

endmodule
